// File: rtl/wb_byte_bridge.sv
// wb_byte_bridge: byte-stream to Wishbone master bridge.
// A command byte (bit7 = we, low bits = address) arrives on the rx valid/ready
// stream. For a write, one data byte follows. Each command runs one
// single-beat Wishbone cycle. A read returns one byte on the tx stream; a
// read that times out returns 8'hFF.
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   rx_data_i/valid_i/ready_o  command/data byte input stream
//   tx_data_o/valid_o/ready_i  read-response byte output stream
//   stb_o, we_o, adr_o, dat_o  Wishbone master request
//   ack_i, dat_i               Wishbone slave response
//   timeout_o                  one-cycle pulse when a bus cycle times out
module wb_byte_bridge #(
   parameter int unsigned WB_DATA_WIDTH = 8,
   parameter int unsigned WB_ADDR_WIDTH = 2,
   parameter int unsigned TIMEOUT       = 255
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [7:0]               rx_data_i,
   input  logic                     rx_valid_i,
   output logic                     rx_ready_o,
   output logic [7:0]               tx_data_o,
   output logic                     tx_valid_o,
   input  logic                     tx_ready_i,
   output logic                     stb_o,
   output logic                     we_o,
   output logic [WB_ADDR_WIDTH-1:0] adr_o,
   output logic [WB_DATA_WIDTH-1:0] dat_o,
   input  logic                     ack_i,
   input  logic [WB_DATA_WIDTH-1:0] dat_i,
   output logic                     timeout_o
);

   localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StData, StBus, StResp} state_e;

   state_e                   state_q, state_d;
   logic [CntW-1:0]          cnt_q, cnt_d;
   logic                     rx_ready_q, rx_ready_d;
   logic [7:0]               tx_data_q, tx_data_d;
   logic                     tx_valid_q, tx_valid_d;
   logic                     stb_q, stb_d;
   logic                     we_q, we_d;
   logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;
   logic                     timeout_q, timeout_d;

   // rx_ready_q is registered, so it is the qualifier of an rx transfer.
   logic rx_fire;
   assign rx_fire = rx_valid_i & rx_ready_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rx_ready_d = rx_ready_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      stb_d      = stb_q;
      we_d       = we_q;
      adr_d      = adr_q;
      dat_d      = dat_q;
      timeout_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            rx_ready_d = 1'b1;
            if (rx_fire) begin
               we_d  = rx_data_i[7];
               adr_d = rx_data_i[WB_ADDR_WIDTH-1:0];
               if (rx_data_i[7]) begin
                  state_d = StData;
               end else begin
                  state_d    = StBus;
                  rx_ready_d = 1'b0;
                  stb_d      = 1'b1;
                  cnt_d      = '0;
               end
            end
         end
         StData: begin
            rx_ready_d = 1'b1;
            if (rx_fire) begin
               dat_d      = rx_data_i;
               state_d    = StBus;
               rx_ready_d = 1'b0;
               stb_d      = 1'b1;
               cnt_d      = '0;
            end
         end
         StBus: begin
            // Ack takes priority over the terminal count on the same edge.
            if (ack_i) begin
               stb_d = 1'b0;
               if (we_q) begin
                  state_d    = StIdle;
                  rx_ready_d = 1'b1;
               end else begin
                  tx_data_d  = dat_i;
                  tx_valid_d = 1'b1;
                  state_d    = StResp;
               end
            end else if (cnt_q == CntLast) begin
               stb_d     = 1'b0;
               timeout_d = 1'b1;
               if (we_q) begin
                  state_d    = StIdle;
                  rx_ready_d = 1'b1;
               end else begin
                  tx_data_d  = 8'hFF;
                  tx_valid_d = 1'b1;
                  state_d    = StResp;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            if (tx_ready_i) begin
               tx_valid_d = 1'b0;
               state_d    = StIdle;
               rx_ready_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         rx_ready_q <= 1'b0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         stb_q      <= 1'b0;
         we_q       <= 1'b0;
         adr_q      <= '0;
         dat_q      <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rx_ready_q <= rx_ready_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         stb_q      <= stb_d;
         we_q       <= we_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
         timeout_q  <= timeout_d;
      end
   end

   assign rx_ready_o = rx_ready_q;
   assign tx_data_o  = tx_data_q;
   assign tx_valid_o = tx_valid_q;
   assign stb_o      = stb_q;
   assign we_o       = we_q;
   assign adr_o      = adr_q;
   assign dat_o      = dat_q;
   assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_wb_byte_bridge.sv
// Bench for wb_byte_bridge: a Wishbone slave with programmable ack latency,
// a negedge bus monitor, and a transaction-level reference model.
module tb_wb_byte_bridge;
   localparam int unsigned TO = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       stb_o, we_o, ack_i, timeout_o;
   logic [1:0] adr_o;
   logic [7:0] dat_o, dat_i;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_byte_bridge #(
      .WB_DATA_WIDTH(8),
      .WB_ADDR_WIDTH(2),
      .TIMEOUT(TO)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .rx_data_i(rx_data),
      .rx_valid_i(rx_valid),
      .rx_ready_o(rx_ready),
      .tx_data_o(tx_data),
      .tx_valid_o(tx_valid),
      .tx_ready_i(tx_ready),
      .stb_o(stb_o),
      .we_o(we_o),
      .adr_o(adr_o),
      .dat_o(dat_o),
      .ack_i(ack_i),
      .dat_i(dat_i),
      .timeout_o(timeout_o)
   );

   // Slave: asserts ack for one cycle after seeing stb for ack_lat edges.
   // ack_lat = 0 means never ack.
   int unsigned ack_lat = 1;
   int unsigned slv_cnt;
   logic        slv_ack;
   logic        stray_ack = 1'b0;
   logic [7:0]  init_mem [4];
   logic [7:0]  slv_mem [4];
   logic [7:0]  ref_mem [4];

   assign ack_i = slv_ack | stray_ack;
   assign dat_i = slv_mem[adr_o];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         slv_ack <= 1'b0;
         slv_cnt <= 0;
         for (int i = 0; i < 4; i++) slv_mem[i] <= init_mem[i];
      end else begin
         if (stb_o && ack_i && we_o) slv_mem[adr_o] <= dat_o;
         if (stb_o && !slv_ack) begin
            if (ack_lat != 0 && slv_cnt == ack_lat - 1) begin
               slv_ack <= 1'b1;
               slv_cnt <= 0;
            end else begin
               slv_cnt <= slv_cnt + 1;
            end
         end else begin
            slv_ack <= 1'b0;
            slv_cnt <= 0;
         end
      end
   end

   // Monitor, sampled mid-cycle.
   int         stb_cyc = 0, to_cyc = 0, wb_n = 0, tx_n = 0, rx_n = 0;
   logic [10:0] wb_log [512];
   logic [7:0]  tx_log [512];

   always @(negedge clk) begin
      if (!rst) begin
         if (stb_o) stb_cyc <= stb_cyc + 1;
         if (timeout_o) to_cyc <= to_cyc + 1;
         if (stb_o && ack_i) begin
            wb_log[wb_n[8:0]] <= {we_o, adr_o, dat_o};
            wb_n <= wb_n + 1;
         end
         if (tx_valid && tx_ready) begin
            tx_log[tx_n[8:0]] <= tx_data;
            tx_n <= tx_n + 1;
         end
         if (rx_valid && rx_ready) rx_n <= rx_n + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, output bit ok);
      ok = 1'b0;
      rx_data = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (rx_ready) ok = 1'b1;
         tick();
      end
      rx_valid = 1'b0;
   endtask

   task automatic reset_pulse(input string name);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({stb_o, tx_valid, timeout_o, rx_ready, we_o, adr_o, dat_o, tx_data} !== '0) begin
         errors++;
         $display("FAIL %s outputs: got stb=%b txv=%b to=%b rdy=%b tx=%h want all 0",
                  name, stb_o, tx_valid, timeout_o, rx_ready, tx_data);
      end
      @(posedge clk);
      #3;
      rst = 1'b0;
      tick();
   endtask

   // One command through the bridge, checked against the transaction model.
   task automatic do_txn(input string name, input logic [7:0] cmd, input logic [7:0] wdat,
                         input int unsigned lat, input int unsigned rdy_dly);
      bit          ok, ok2, stable, busy_rdy;
      logic        we;
      logic [1:0]  adr;
      bit          acked;
      int          exp_stb, n;
      logic [7:0]  exp_tx;
      logic [10:0] ent;
      int          s_stb, s_to, s_wb, s_tx, s_rx;
      we      = cmd[7];
      adr     = cmd[1:0];
      acked   = (lat >= 1) && (lat <= TO - 1);
      exp_stb = acked ? int'(lat) + 1 : int'(TO);
      exp_tx  = acked ? ref_mem[adr] : 8'hFF;
      ack_lat = lat;
      s_stb = stb_cyc; s_to = to_cyc; s_wb = wb_n; s_tx = tx_n; s_rx = rx_n;

      send_byte(cmd, ok);
      ok2 = 1'b1;
      if (we) send_byte(wdat, ok2);
      checks++;
      if (!(ok && ok2)) begin
         errors++;
         $display("FAIL %s rx_accept: got cmd=%b dat=%b want 1 1", name, ok, ok2);
      end

      n = 0;
      while (n < 40 && !(we ? rx_ready : tx_valid)) begin
         tick();
         n++;
      end
      checks++;
      if (n !== exp_stb) begin
         errors++;
         $display("FAIL %s latency: got %0d want %0d", name, n, exp_stb);
      end

      if (!we) begin
         stable = 1'b1;
         busy_rdy = 1'b0;
         for (int i = 0; i < int'(rdy_dly); i++) begin
            if (tx_data !== exp_tx || tx_valid !== 1'b1) stable = 1'b0;
            if (rx_ready !== 1'b0) busy_rdy = 1'b1;
            tick();
         end
         checks++;
         if (tx_data !== exp_tx || !stable || busy_rdy) begin
            errors++;
            $display("FAIL %s tx_hold: got data=%h stable=%b rx_ready_seen=%b want data=%h 1 0",
                     name, tx_data, stable, busy_rdy, exp_tx);
         end
         tx_ready = 1'b1;
         tick();
         tx_ready = 1'b0;
         checks++;
         if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s tx_valid_drop: got %b want 0", name, tx_valid);
         end
      end
      tick();

      checks++;
      if (stb_cyc - s_stb !== exp_stb) begin
         errors++;
         $display("FAIL %s stb_cycles: got %0d want %0d", name, stb_cyc - s_stb, exp_stb);
      end
      checks++;
      if (to_cyc - s_to !== (acked ? 0 : 1)) begin
         errors++;
         $display("FAIL %s timeout_pulse: got %0d want %0d", name, to_cyc - s_to, acked ? 0 : 1);
      end
      checks++;
      if (wb_n - s_wb !== (acked ? 1 : 0)) begin
         errors++;
         $display("FAIL %s wb_cycles: got %0d want %0d", name, wb_n - s_wb, acked ? 1 : 0);
      end else if (acked) begin
         ent = wb_log[s_wb[8:0]];
         checks++;
         if (ent[10] !== we || ent[9:8] !== adr || (we && ent[7:0] !== wdat)) begin
            errors++;
            $display("FAIL %s wb_beat: got we=%b adr=%0d dat=%h want we=%b adr=%0d dat=%h",
                     name, ent[10], ent[9:8], ent[7:0], we, adr, wdat);
         end
      end
      checks++;
      if (tx_n - s_tx !== (we ? 0 : 1)) begin
         errors++;
         $display("FAIL %s tx_bytes: got %0d want %0d", name, tx_n - s_tx, we ? 0 : 1);
      end else if (!we) begin
         checks++;
         if (tx_log[s_tx[8:0]] !== exp_tx) begin
            errors++;
            $display("FAIL %s tx_byte: got %h want %h", name, tx_log[s_tx[8:0]], exp_tx);
         end
      end
      checks++;
      if (rx_n - s_rx !== (we ? 2 : 1)) begin
         errors++;
         $display("FAIL %s rx_consumed: got %0d want %0d", name, rx_n - s_rx, we ? 2 : 1);
      end

      if (we && acked) ref_mem[adr] = wdat;
   endtask

   task automatic test_reset();
      bit ok, found;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({stb_o, tx_valid, timeout_o, rx_ready, we_o, adr_o, dat_o, tx_data} !== '0) begin
         errors++;
         $display("FAIL reset_state: got stb=%b txv=%b to=%b rdy=%b want all 0",
                  stb_o, tx_valid, timeout_o, rx_ready);
      end
      #2;
      rst = 1'b0;
      tick();

      // Mid-BUS reset.
      ack_lat = 0;
      send_byte(8'h03, ok);
      tick();
      tick();
      checks++;
      if (stb_o !== 1'b1 || !ok) begin
         errors++;
         $display("FAIL reset_pre_bus: got stb=%b accepted=%b want 1 1", stb_o, ok);
      end
      reset_pulse("reset_mid_bus");

      // Reset while the timeout pulse and response byte are both up.
      send_byte(8'h02, ok);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (timeout_o) found = 1'b1;
         else tick();
      end
      checks++;
      if (!found || tx_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_timeout: got to=%b txv=%b want 1 1", found, tx_valid);
      end
      reset_pulse("reset_mid_timeout");

      // A write command left waiting for its data byte must be discarded.
      send_byte(8'h81, ok);
      reset_pulse("reset_mid_data");
      do_txn("reset_next_cmd", 8'h01, 8'h00, 1, 0);
   endtask

   task automatic test_stray_ack();
      bit bad;
      int s_wb;
      s_wb = wb_n;
      bad = 1'b0;
      stray_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (stb_o || tx_valid || timeout_o || !rx_ready) bad = 1'b1;
      end
      stray_ack = 1'b0;
      tick();
      checks++;
      if (bad || wb_n !== s_wb) begin
         errors++;
         $display("FAIL stray_ack: got disturbed=%b wb_cycles=%0d want 0 0", bad, wb_n - s_wb);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  bytes [5];
      logic [10:0] exp [3];
      logic [7:0]  exp_rd;
      int          i, n, s_wb, s_tx, s_rx, s_stb;
      bit          bad;
      bytes[0] = 8'hD5;                 // write, adr 1
      bytes[1] = 8'($urandom);
      bytes[2] = 8'h7A;                 // read, adr 2
      bytes[3] = 8'hA3;                 // write, adr 3
      bytes[4] = 8'($urandom);
      exp[0] = {1'b1, 2'd1, bytes[1]};
      exp[1] = {1'b0, 2'd2, 8'h00};
      exp[2] = {1'b1, 2'd3, bytes[4]};
      exp_rd = ref_mem[2];
      s_wb = wb_n; s_tx = tx_n; s_rx = rx_n; s_stb = stb_cyc;
      ack_lat = 2;
      tx_ready = 1'b1;
      i = 0;
      n = 0;
      while (i < 5 && n < 200) begin
         rx_data = bytes[i];
         rx_valid = 1'b1;
         if (rx_ready) i++;
         tick();
         n++;
      end
      rx_valid = 1'b0;
      repeat (8) tick();
      tx_ready = 1'b0;

      checks++;
      if (i !== 5 || rx_n - s_rx !== 5) begin
         errors++;
         $display("FAIL b2b_rx: got sent=%0d consumed=%0d want 5 5", i, rx_n - s_rx);
      end
      checks++;
      if (wb_n - s_wb !== 3 || stb_cyc - s_stb !== 9) begin
         errors++;
         $display("FAIL b2b_wb: got cycles=%0d stb=%0d want 3 9", wb_n - s_wb, stb_cyc - s_stb);
      end else begin
         bad = 1'b0;
         for (int k = 0; k < 3; k++) begin
            if (wb_log[9'(s_wb + k)][10:8] !== exp[k][10:8]) bad = 1'b1;
            if (exp[k][10] && wb_log[9'(s_wb + k)] !== exp[k]) bad = 1'b1;
         end
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL b2b_order: got %h %h %h want %h %h %h",
                     wb_log[9'(s_wb)], wb_log[9'(s_wb + 1)], wb_log[9'(s_wb + 2)],
                     exp[0], exp[1], exp[2]);
         end
      end
      checks++;
      if (tx_n - s_tx !== 1 || tx_log[s_tx[8:0]] !== exp_rd) begin
         errors++;
         $display("FAIL b2b_tx: got n=%0d byte=%h want 1 %h", tx_n - s_tx, tx_log[s_tx[8:0]],
                  exp_rd);
      end
      ref_mem[1] = bytes[1];
      ref_mem[3] = bytes[4];
   endtask

   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         do_txn("random", 8'($urandom), 8'($urandom), $urandom_range(0, TO), $urandom_range(0, 3));
      end
   endtask

   initial begin
      rst = 1'b0;
      rx_data = '0;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) init_mem[i] = 8'($urandom);
      init_mem[1] = 8'hC3;
      for (int i = 0; i < 4; i++) ref_mem[i] = init_mem[i];

      test_reset();
      do_txn("write", 8'h82, 8'h5A, 1, 0);
      do_txn("read", 8'h01, 8'h00, 1, 5);
      do_txn("timeout", 8'h00, 8'h00, 0, 2);
      do_txn("race_ack", 8'h02, 8'h00, TO - 1, 1);
      do_txn("late_ack", 8'h03, 8'h00, TO, 1);
      test_stray_ack();
      test_back_to_back();
      test_random();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end
endmodule
